// File: rtl/signed_sat_accumulator_if.sv
// rtl/signed_sat_accumulator_if.sv - sample-in / result-out bundle for the saturating accumulator
interface signed_sat_accumulator_if #(
    parameter int WIDTH = 8
);
    logic             clear;
    logic             up_valid;
    logic [WIDTH-1:0] up_data;
    logic             down_valid;
    logic [WIDTH-1:0] down_data;
    logic             down_last;
    logic             down_sat;
    logic             sat_pos_sticky;
    logic             sat_neg_sticky;

    modport master (
        output clear, up_valid, up_data,
        input  down_valid, down_data, down_last, down_sat, sat_pos_sticky, sat_neg_sticky
    );

    modport slave (
        input  clear, up_valid, up_data,
        output down_valid, down_data, down_last, down_sat, sat_pos_sticky, sat_neg_sticky
    );
endinterface

// File: rtl/signed_sat_accumulator.sv
// rtl/signed_sat_accumulator.sv - framed signed running sum that clamps instead of wrapping
module signed_sat_accumulator #(
    parameter int WIDTH     = 8,
    parameter int FRAME_LEN = 8
) (
    input logic                      clk,
    input logic                      rst,
    signed_sat_accumulator_if.slave  bus
);
    localparam int CNT_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRAME_LEN - 1);
    localparam logic [WIDTH-1:0] MAX_VAL  = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};

    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             down_valid_q, down_valid_d;
    logic [WIDTH-1:0] down_data_q, down_data_d;
    logic             down_last_q, down_last_d;
    logic             down_sat_q, down_sat_d;
    logic             sat_pos_q, sat_pos_d;
    logic             sat_neg_q, sat_neg_d;

    logic [WIDTH-1:0] base;
    logic [CNT_W-1:0] cnt_base;
    logic [WIDTH:0]   raw;
    logic [WIDTH-1:0] clamped;
    logic             ovf_pos;
    logic             ovf_neg;
    logic             is_last;

    // acc is zeroed when a frame closes, so the following sample naturally starts from base 0
    always_comb begin
        base     = bus.clear ? '0 : acc_q;
        cnt_base = bus.clear ? '0 : cnt_q;
        raw      = {base[WIDTH-1], base} + {bus.up_data[WIDTH-1], bus.up_data};
        ovf_pos  = ~raw[WIDTH] &  raw[WIDTH-1];
        ovf_neg  =  raw[WIDTH] & ~raw[WIDTH-1];
        clamped  = ovf_pos ? MAX_VAL : (ovf_neg ? MIN_VAL : raw[WIDTH-1:0]);
        is_last  = (cnt_base == CNT_LAST);

        acc_d        = base;
        cnt_d        = cnt_base;
        down_valid_d = 1'b0;
        down_data_d  = down_data_q;
        down_last_d  = down_last_q;
        down_sat_d   = down_sat_q;
        sat_pos_d    = bus.clear ? 1'b0 : sat_pos_q;
        sat_neg_d    = bus.clear ? 1'b0 : sat_neg_q;

        if (bus.up_valid) begin
            acc_d        = is_last ? '0 : clamped;
            cnt_d        = is_last ? '0 : cnt_base + 1'b1;
            down_valid_d = 1'b1;
            down_data_d  = clamped;
            down_last_d  = is_last;
            down_sat_d   = ovf_pos | ovf_neg;
            sat_pos_d    = sat_pos_d | ovf_pos;
            sat_neg_d    = sat_neg_d | ovf_neg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q        <= '0;
            cnt_q        <= '0;
            down_valid_q <= 1'b0;
            down_data_q  <= '0;
            down_last_q  <= 1'b0;
            down_sat_q   <= 1'b0;
            sat_pos_q    <= 1'b0;
            sat_neg_q    <= 1'b0;
        end else begin
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            down_valid_q <= down_valid_d;
            down_data_q  <= down_data_d;
            down_last_q  <= down_last_d;
            down_sat_q   <= down_sat_d;
            sat_pos_q    <= sat_pos_d;
            sat_neg_q    <= sat_neg_d;
        end
    end

    assign bus.down_valid     = down_valid_q;
    assign bus.down_data      = down_data_q;
    assign bus.down_last      = down_last_q;
    assign bus.down_sat       = down_sat_q;
    assign bus.sat_pos_sticky = sat_pos_q;
    assign bus.sat_neg_sticky = sat_neg_q;
endmodule

// File: tb/tb_signed_sat_accumulator.sv
// tb/tb_signed_sat_accumulator.sv - directed self-checking bench for signed_sat_accumulator
module tb_signed_sat_accumulator;
    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    signed_sat_accumulator_if #(.WIDTH(4)) a_if ();
    signed_sat_accumulator_if #(.WIDTH(8)) b_if ();

    signed_sat_accumulator #(.WIDTH(4), .FRAME_LEN(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a_if.slave)
    );

    signed_sat_accumulator #(.WIDTH(8), .FRAME_LEN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive_a(input logic v, input logic [3:0] d, input logic c);
        a_if.up_valid = v;
        a_if.up_data  = d;
        a_if.clear    = c;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a_if.up_valid = 1'b1; a_if.up_data = 4'h5; a_if.clear = 1'b0;
        b_if.up_valid = 1'b1; b_if.up_data = 8'h05; b_if.clear = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_cmp++; if (a_if.down_valid !== 1'b0) begin n_bad++; $display("FAIL rst_valid got=%b exp=0", a_if.down_valid); end
        n_cmp++; if (a_if.down_data !== 4'h0) begin n_bad++; $display("FAIL rst_data got=%h exp=0", a_if.down_data); end
        n_cmp++; if (a_if.down_last !== 1'b0) begin n_bad++; $display("FAIL rst_last got=%b exp=0", a_if.down_last); end
        n_cmp++; if (a_if.down_sat !== 1'b0) begin n_bad++; $display("FAIL rst_sat got=%b exp=0", a_if.down_sat); end
        n_cmp++; if ({a_if.sat_pos_sticky, a_if.sat_neg_sticky} !== 2'b00) begin n_bad++; $display("FAIL rst_sticky got=%b%b exp=00", a_if.sat_pos_sticky, a_if.sat_neg_sticky); end
        n_cmp++; if (b_if.down_valid !== 1'b0) begin n_bad++; $display("FAIL rst_b_valid got=%b exp=0", b_if.down_valid); end
        rst = 1'b0;
        b_if.up_valid = 1'b0;
        drive_a(1'b0, 4'h5, 1'b0);
        n_cmp++; if (a_if.down_valid !== 1'b0 || a_if.down_data !== 4'h0) begin n_bad++; $display("FAIL rst_drop got=%b/%h exp=0/0", a_if.down_valid, a_if.down_data); end
    endtask

    task automatic test_pos_clamp();
        logic [3:0] smp   [4] = '{4'h3, 4'h3, 4'h3, 4'hE};
        logic [3:0] exp_d [4] = '{4'h3, 4'h6, 4'h7, 4'h5};
        logic       exp_s [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_p [4] = '{1'b0, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, smp[i], 1'b0);
            n_cmp++;
            if ({a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky}
                !== {1'b1, exp_d[i], exp_s[i], exp_l[i], exp_p[i], 1'b0}) begin
                n_bad++;
                $display("FAIL pos_clamp[%0d] got v=%b d=%h s=%b l=%b p=%b n=%b exp v=1 d=%h s=%b l=%b p=%b n=0", i,
                         a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky,
                         a_if.sat_neg_sticky, exp_d[i], exp_s[i], exp_l[i], exp_p[i]);
            end
        end
    endtask

    task automatic test_neg_clamp();
        logic [3:0] smp   [4] = '{4'hB, 4'hB, 4'h4, 4'hF};
        logic [3:0] exp_d [4] = '{4'hB, 4'h8, 4'hC, 4'hB};
        logic       exp_s [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
        logic       exp_l [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
        logic       exp_n [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, smp[i], 1'b0);
            n_cmp++;
            if ({a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky}
                !== {1'b1, exp_d[i], exp_s[i], exp_l[i], 1'b1, exp_n[i]}) begin
                n_bad++;
                $display("FAIL neg_clamp[%0d] got v=%b d=%h s=%b l=%b p=%b n=%b exp v=1 d=%h s=%b l=%b p=1 n=%b", i,
                         a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky,
                         a_if.sat_neg_sticky, exp_d[i], exp_s[i], exp_l[i], exp_n[i]);
            end
        end
    endtask

    task automatic test_gap();
        drive_a(1'b1, 4'h2, 1'b0);
        n_cmp++; if (a_if.down_valid !== 1'b1 || a_if.down_data !== 4'h2) begin n_bad++; $display("FAIL gap_first got=%b/%h exp=1/2", a_if.down_valid, a_if.down_data); end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b0, 4'h7, 1'b0);
            n_cmp++;
            if ({a_if.down_valid, a_if.down_data, a_if.down_last, a_if.down_sat} !== {1'b0, 4'h2, 1'b0, 1'b0}) begin
                n_bad++;
                $display("FAIL gap_idle[%0d] got v=%b d=%h l=%b s=%b exp v=0 d=2 l=0 s=0", i,
                         a_if.down_valid, a_if.down_data, a_if.down_last, a_if.down_sat);
            end
        end
        drive_a(1'b1, 4'h3, 1'b0);
        n_cmp++; if ({a_if.down_valid, a_if.down_data, a_if.down_last} !== {1'b1, 4'h5, 1'b0}) begin n_bad++; $display("FAIL gap_second got=%b/%h/%b exp=1/5/0", a_if.down_valid, a_if.down_data, a_if.down_last); end
        n_cmp++; if ({a_if.sat_pos_sticky, a_if.sat_neg_sticky} !== 2'b11) begin n_bad++; $display("FAIL gap_sticky got=%b%b exp=11", a_if.sat_pos_sticky, a_if.sat_neg_sticky); end
    endtask

    task automatic test_clear();
        logic [3:0] exp_d [3] = '{4'h3, 4'h4, 4'h5};
        logic       exp_l [3] = '{1'b0, 1'b0, 1'b1};
        drive_a(1'b1, 4'h2, 1'b1);
        n_cmp++;
        if ({a_if.down_valid, a_if.down_data, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky} !== {1'b1, 4'h2, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL clear_with_sample got v=%b d=%h l=%b p=%b n=%b exp v=1 d=2 l=0 p=0 n=0",
                     a_if.down_valid, a_if.down_data, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky);
        end
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 4'h1, 1'b0);
            n_cmp++;
            if ({a_if.down_data, a_if.down_last} !== {exp_d[i], exp_l[i]}) begin
                n_bad++;
                $display("FAIL clear_frame[%0d] got d=%h l=%b exp d=%h l=%b", i, a_if.down_data, a_if.down_last, exp_d[i], exp_l[i]);
            end
        end
        drive_a(1'b1, 4'h6, 1'b0);
        drive_a(1'b1, 4'h7, 1'b0);
        n_cmp++; if ({a_if.down_data, a_if.down_sat, a_if.sat_pos_sticky} !== {4'h7, 1'b1, 1'b1}) begin n_bad++; $display("FAIL clear_presat got d=%h s=%b p=%b exp d=7 s=1 p=1", a_if.down_data, a_if.down_sat, a_if.sat_pos_sticky); end
        drive_a(1'b0, 4'h0, 1'b1);
        n_cmp++;
        if ({a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky} !== {1'b0, 4'h7, 1'b1, 1'b0, 2'b00}) begin
            n_bad++;
            $display("FAIL clear_alone got v=%b d=%h s=%b l=%b p=%b n=%b exp v=0 d=7 s=1 l=0 p=0 n=0",
                     a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last, a_if.sat_pos_sticky, a_if.sat_neg_sticky);
        end
        drive_a(1'b1, 4'hD, 1'b0);
        n_cmp++; if ({a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last} !== {1'b1, 4'hD, 1'b0, 1'b0}) begin n_bad++; $display("FAIL clear_restart got v=%b d=%h s=%b l=%b exp v=1 d=d s=0 l=0", a_if.down_valid, a_if.down_data, a_if.down_sat, a_if.down_last); end
        drive_a(1'b0, 4'h0, 1'b0);
    endtask

    task automatic test_limits();
        logic [7:0] smp [3] = '{8'h7F, 8'h80, 8'hFF};
        for (int i = 0; i < 3; i++) begin
            b_if.up_valid = 1'b1;
            b_if.up_data  = smp[i];
            b_if.clear    = 1'b0;
            @(negedge clk);
            n_cmp++;
            if ({b_if.down_valid, b_if.down_data, b_if.down_last, b_if.down_sat, b_if.sat_pos_sticky, b_if.sat_neg_sticky}
                !== {1'b1, smp[i], 1'b1, 1'b0, 2'b00}) begin
                n_bad++;
                $display("FAIL limits[%0d] got v=%b d=%h l=%b s=%b p=%b n=%b exp v=1 d=%h l=1 s=0 p=0 n=0", i,
                         b_if.down_valid, b_if.down_data, b_if.down_last, b_if.down_sat, b_if.sat_pos_sticky,
                         b_if.sat_neg_sticky, smp[i]);
            end
        end
        b_if.up_valid = 1'b0;
        @(negedge clk);
        n_cmp++; if ({b_if.down_valid, b_if.down_data, b_if.down_last} !== {1'b0, 8'hFF, 1'b1}) begin n_bad++; $display("FAIL limits_hold got v=%b d=%h l=%b exp v=0 d=ff l=1", b_if.down_valid, b_if.down_data, b_if.down_last); end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        rst   = 1'b1;
        a_if.clear = 1'b0; a_if.up_valid = 1'b0; a_if.up_data = '0;
        b_if.clear = 1'b0; b_if.up_valid = 1'b0; b_if.up_data = '0;
        @(negedge clk);
        test_reset();
        test_pos_clamp();
        test_neg_clamp();
        test_gap();
        test_clear();
        test_limits();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/signed_sat_accumulator.md
Name: signed_sat_accumulator

Overview:
- Streaming signed accumulator with saturation, parametrised in data width.
- Each accepted sample is added to a running sum. The sum clamps to the most-positive or most-negative value instead of wrapping.
- Sums are framed: the accumulator restarts automatically after FRAME_LEN samples. An explicit clear also restarts it.
- Sits between a sample source and downstream logic that needs a bounded running total plus sticky overflow status.

Parameters:
- WIDTH, 8: data and accumulator width in bits, two's complement; legal range 2..32.
- FRAME_LEN, 8: samples per frame; legal range 1..65535.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- rst  input  1  synchronous reset, active-high.
- clear  input  1  restart the accumulator and frame counter, and clear the sticky flags.
- up_valid  input  1  up_data is valid this cycle; always accepted, no backpressure.
- up_data  input  WIDTH  signed sample.
- down_valid  output  1  registered result valid.
- down_data  output  WIDTH  signed saturated running sum after this sample.
- down_last  output  1  this result closes a frame.
- down_sat  output  1  this result was clamped.
- sat_pos_sticky  output  1  a positive clamp has occurred since the last rst or clear.
- sat_neg_sticky  output  1  a negative clamp has occurred since the last rst or clear.

Behaviour:
- Limits: MAX = 2^(WIDTH-1)-1 and MIN = -2^(WIDTH-1).
- Raw sum: computed at WIDTH+1 bits, sign-extended, as base + up_data.
- Base:
  - 0 if clear, or if the previous accepted sample closed a frame;
  - otherwise the accumulator acc.
- Clamping:
  - raw > MAX gives MAX with down_sat=1;
  - raw < MIN gives MIN with down_sat=1;
  - otherwise the raw value, with down_sat=0.
- Equivalent sign rule for the clamp: both operands share a sign and the WIDTH-bit result sign differs.
- Latency: exactly 1 cycle. A sample accepted at edge N appears on down_* in the cycle after edge N.
- down_valid is high for one cycle per accepted sample.
- When up_valid=0:
  - down_valid=0 next cycle;
  - down_data, down_last and down_sat hold their last values;
  - acc and the frame counter hold.
- Frame counter cnt (0..FRAME_LEN-1):
  - increments on each accepted sample;
  - when the FRAME_LEN-th sample is accepted (cnt==FRAME_LEN-1), the result carries down_last=1 and cnt returns to 0;
  - the next sample starts from base 0.
- FRAME_LEN=1: every result has down_last=1 and down_data=up_data. Single values cannot saturate.
- Sticky flags:
  - sat_pos_sticky is set on a positive clamp; sat_neg_sticky is set on a negative clamp.
  - They are not cleared at frame boundaries; only rst or clear clears them.
- clear without up_valid:
  - next cycle acc=0, cnt=0, stickies=0, down_valid=0;
  - down_data, down_last and down_sat hold.
- clear with up_valid in the same cycle:
  - the sample starts a new frame from base 0 (cnt becomes 1, or the frame closes if FRAME_LEN=1);
  - stickies become 0, since a single sample cannot clamp.
- rst:
  - has priority over clear and up_valid;
  - next cycle acc=0, cnt=0, and every output is 0;
  - a sample presented during rst is dropped.
- No internal state is kept beyond acc, cnt, the output registers and the stickies.

Test Plan (WIDTH=4, FRAME_LEN=4 unless noted):
- Reset: assert rst 2 cycles with up_valid=1, up_data=5 -> all outputs 0; the first result after release is based on 0.
- Positive clamp: samples 3,3,3,-2 back-to-back ->
  - down_data 3,6,7,5;
  - down_sat 0,0,1,0;
  - down_last only on the 4th;
  - sat_pos_sticky=1 from the 3rd result on.
- Negative clamp and frame restart: continue with -5,-5,4,-1 ->
  - down_data -5,-8,-4,-5;
  - down_sat on the 2nd;
  - down_last on the 4th;
  - both stickies=1.
- Gapped input: 2, idle 3 cycles, 3 ->
  - down_valid pulses twice;
  - down_data holds 2 during the gap, then 5;
  - acc and cnt unchanged during the gap.
- Clear:
  - clear with up_valid=1 and up_data=2 at mid-frame cnt=2 with stickies set -> down_data=2, stickies 0; down_last comes on the 4th sample after the clear.
  - clear alone -> down_valid=0; the next sample's result equals the sample.
- Limits, WIDTH=8, FRAME_LEN=1: 127, -128, -1 -> down_data 127, -128, -1; down_last=1 on every result; down_sat always 0.
